// File: rtl/wash_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wash_pkg
// Description : Shared types, wash-selection encodings and the round-robin
//               grant helper for the wash bay scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package wash_pkg;

    // Widest bay count the round-robin helper supports
    localparam int MAX_BAYS = 8;

    // Wash selection encodings as sent by the POS
    localparam logic [1:0] SEL_NONE       = 2'd0;
    localparam logic [1:0] SEL_BASIC      = 2'd1;
    localparam logic [1:0] SEL_BASIC_PLUS = 2'd2;
    localparam logic [1:0] SEL_DETAIL     = 2'd3;

    // Per-bay lifecycle
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        FAULT = 2'd3
    } bay_state_t;

    // One-hot grant to the first eligible bay at or above ptr, wrapping at n.
    // ptr is always below n, so a single subtraction keeps the index in range.
    function automatic logic [MAX_BAYS-1:0] rr_pick(
        input logic [MAX_BAYS-1:0] eligible,
        input logic [2:0]          ptr,
        input logic [3:0]          n
    );
        logic [MAX_BAYS-1:0] grant;
        logic                found;
        logic [3:0]          idx;
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_BAYS; k++) begin
            idx = {1'b0, ptr} + 4'(k);
            if (idx >= n) begin
                idx = idx - n;
            end
            if ((4'(k) < n) && !found && eligible[idx[2:0]]) begin
                grant[idx[2:0]] = 1'b1;
                found           = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wash_order_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wash_order_fifo
// Description : Synchronous order FIFO. Pointers carry an extra wrap bit so
//               full and empty are told apart by the pointer difference.
// Revision    : 1.0 - initial release
// ============================================================================
module wash_order_fifo
    import wash_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [W-1:0]             i_data,
    input  logic                     i_pop,
    output logic [W-1:0]             o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int c_aw    = $clog2(DEPTH);
    localparam int c_cnt_w = c_aw + 1;

    logic [W-1:0]       r_mem [DEPTH];
    logic [c_aw:0]      r_wr_ptr;
    logic [c_aw:0]      r_rd_ptr;
    logic [c_cnt_w-1:0] w_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign w_count   = r_wr_ptr - r_rd_ptr;
    assign o_count   = w_count;
    assign o_full    = (w_count == c_cnt_w'(DEPTH));
    assign o_empty   = (w_count == '0);
    assign o_data    = r_mem[r_rd_ptr[c_aw-1:0]];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Advance read/write pointers independently; simultaneous push/pop leaves count unchanged
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Order storage; contents need no reset because the pointers gate visibility
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[c_aw-1:0]] <= i_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/wash_bay_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : wash_bay_scheduler
// Description : Buffers paid orders and dispatches them round-robin to free
//               wash bays, tracking each bay through start/busy/complete with
//               a watchdog that faults overrunning bays.
// Revision    : 1.0 - initial release
// ============================================================================
module wash_bay_scheduler
    import wash_pkg::*;
#(
    parameter int NUM_BAYS        = 4,
    parameter int QUEUE_DEPTH     = 8,
    parameter int WATCHDOG_CYCLES = 4096,
    parameter int CNT_W           = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           order_valid,
    input  logic [1:0]                     order_sel,
    output logic                           order_ready,
    input  logic [NUM_BAYS-1:0]            bay_avail,
    input  logic [NUM_BAYS-1:0]            bay_done,
    input  logic [NUM_BAYS-1:0]            fault_clear,
    output logic [NUM_BAYS-1:0]            bay_start,
    output logic [2*NUM_BAYS-1:0]          bay_sel,
    output logic [NUM_BAYS-1:0]            bay_fault,
    output logic [$clog2(QUEUE_DEPTH):0]   queue_count,
    output logic [CNT_W-1:0]               washes_done
);

    localparam int c_ptr_w = $clog2(NUM_BAYS);
    localparam int c_wd_w  = $clog2(WATCHDOG_CYCLES);
    localparam logic [c_wd_w-1:0] c_wd_max = c_wd_w'(WATCHDOG_CYCLES - 1);

    logic                  w_full;
    logic                  w_empty;
    logic [1:0]            w_head_sel;
    logic                  w_push;
    logic                  w_pop;
    logic [NUM_BAYS-1:0]   w_eligible;
    logic [NUM_BAYS-1:0]   w_grant;
    logic [NUM_BAYS-1:0]   w_complete;
    logic [MAX_BAYS-1:0]   w_elig_pad;
    logic [MAX_BAYS-1:0]   w_pick;
    logic [2:0]            w_ptr_pad;
    logic [c_ptr_w-1:0]    r_rr_ptr;
    logic [c_ptr_w-1:0]    w_grant_idx;
    logic [c_ptr_w-1:0]    w_rr_nxt;
    logic [3:0]            w_done_cnt;
    logic [CNT_W-1:0]      r_washes;

    // Readiness depends on occupancy alone, so a full FIFO never takes a push
    // even if a dispatch frees a slot on the same edge
    assign order_ready = !w_full;
    assign w_push      = order_valid && !w_full && (order_sel != SEL_NONE);
    assign w_pop       = !w_empty && (|w_eligible);
    assign washes_done = r_washes;

    wash_order_fifo #(
        .DEPTH (QUEUE_DEPTH),
        .W     (2)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (order_sel),
        .i_pop   (w_pop),
        .o_data  (w_head_sel),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (queue_count)
    );

    // Round-robin grant search and next pointer just past the granted bay
    always_comb begin
        w_elig_pad                = '0;
        w_elig_pad[NUM_BAYS-1:0]  = w_eligible;
        w_ptr_pad                 = '0;
        w_ptr_pad[c_ptr_w-1:0]    = r_rr_ptr;
        w_pick                    = rr_pick(w_elig_pad, w_ptr_pad, 4'(NUM_BAYS));
        w_grant                   = w_pop ? w_pick[NUM_BAYS-1:0] : '0;
        w_grant_idx               = '0;
        for (int k = 0; k < MAX_BAYS; k++) begin
            if (w_pick[k]) begin
                w_grant_idx = c_ptr_w'(k);
            end
        end
        w_rr_nxt = (w_grant_idx == c_ptr_w'(NUM_BAYS - 1)) ? '0 : w_grant_idx + c_ptr_w'(1);
    end

    // Round-robin pointer moves only when an order is actually dispatched
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr <= '0;
        end else if (w_pop) begin
            r_rr_ptr <= w_rr_nxt;
        end
    end

    // Count bays completing this cycle
    always_comb begin
        w_done_cnt = '0;
        for (int i = 0; i < NUM_BAYS; i++) begin
            w_done_cnt = w_done_cnt + {3'b000, w_complete[i]};
        end
    end

    // Completed-wash counter, wraps naturally
    always_ff @(posedge clk) begin
        if (reset) begin
            r_washes <= '0;
        end else begin
            r_washes <= r_washes + CNT_W'(w_done_cnt);
        end
    end

    generate
        for (genvar i = 0; i < NUM_BAYS; i++) begin : g_bay
            bay_state_t        r_state;
            bay_state_t        w_state_nxt;
            logic [c_wd_w-1:0] r_wd;
            logic [c_wd_w-1:0] w_wd_nxt;
            logic [1:0]        r_sel;

            assign w_eligible[i]     = (r_state == IDLE) && bay_avail[i];
            assign w_complete[i]     = (r_state == BUSY) && bay_done[i];
            assign bay_start[i]      = (r_state == START);
            assign bay_fault[i]      = (r_state == FAULT);
            assign bay_sel[2*i +: 2] = r_sel;

            // Bay state, watchdog and latched selection registers
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_state <= IDLE;
                    r_wd    <= '0;
                    r_sel   <= '0;
                end else begin
                    r_state <= w_state_nxt;
                    r_wd    <= w_wd_nxt;
                    if (w_grant[i]) begin
                        r_sel <= w_head_sel;
                    end
                end
            end

            // Bay lifecycle; completion outranks watchdog expiry on the same cycle
            always_comb begin
                w_state_nxt = r_state;
                w_wd_nxt    = r_wd;
                case (r_state)
                    IDLE: begin
                        if (w_grant[i]) begin
                            w_state_nxt = START;
                        end
                    end
                    START: begin
                        w_state_nxt = BUSY;
                        w_wd_nxt    = '0;
                    end
                    BUSY: begin
                        if (bay_done[i]) begin
                            w_state_nxt = IDLE;
                        end else if (r_wd == c_wd_max) begin
                            w_state_nxt = FAULT;
                        end else begin
                            w_wd_nxt = r_wd + c_wd_w'(1);
                        end
                    end
                    FAULT: begin
                        if (fault_clear[i]) begin
                            w_state_nxt = IDLE;
                        end
                    end
                    default: begin
                        w_state_nxt = IDLE;
                    end
                endcase
            end
        end
    endgenerate

endmodule
`default_nettype wire
